// File: rtl/int_sched_pkg.sv
// Shared types and sizes for the interrupt scheduler.
package int_sched_pkg;

  localparam int NUM_SRC = 4;
  localparam int VEC_W   = 2;
  localparam int CNT_W   = 4;

  // Entry path: IDLE -> DRAIN -> PUSH_PC -> PUSH_FLAGS -> VECTOR -> IDLE
  // Return path: IDLE -> POP_FLAGS -> POP_PC -> IDLE
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_DRAIN      = 3'd1,
    ST_PUSH_PC    = 3'd2,
    ST_PUSH_FLAGS = 3'd3,
    ST_VECTOR     = 3'd4,
    ST_POP_FLAGS  = 3'd5,
    ST_POP_PC     = 3'd6
  } state_t;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: lowest-index set bit wins, o_valid when any bit is set.
module irq_prio_enc
  import int_sched_pkg::*;
(
  input  logic [NUM_SRC-1:0] i_req,
  output logic [VEC_W-1:0]   o_idx,
  output logic               o_valid
);

  // Scan from the highest index down so the lowest set index is assigned last.
  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_idx   = VEC_W'(i);
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/interrupt_scheduler.sv
// Interrupt entry/return sequencer: latches irq edges, drains the pipeline,
// pushes PC and flags, vectors to the winning source, and pops on RTI.
//
// Memory handshake: each push_*/pop_* output is a request held high for as
// long as the FSM sits in that state; the request completes (and the FSM
// advances) only in a cycle where mem_busy is low, so mem_busy acts as an
// inverted ready and the request is never withdrawn before it is accepted.
module interrupt_scheduler
  import int_sched_pkg::*;
#(
  parameter int DRAIN_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq,
  input  logic [NUM_SRC-1:0] irq_en,
  input  logic               rti,
  input  logic               mem_busy,
  output logic               stall,
  output logic               flush,
  output logic               push_pc,
  output logic               push_flags,
  output logic               pop_pc,
  output logic               pop_flags,
  output logic               load_vec,
  output logic [VEC_W-1:0]   vec_id,
  output logic [NUM_SRC-1:0] ack,
  output logic               in_service,
  output state_t             o_dbg_state,
  output logic [NUM_SRC-1:0] o_dbg_pending
);

  localparam logic [CNT_W-1:0] LP_CNT_LOAD = CNT_W'(DRAIN_CYCLES - 1);

  state_t             r_state;
  state_t             w_next_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [NUM_SRC-1:0] r_pending;
  logic [NUM_SRC-1:0] r_irq_prev;
  logic               r_gie;
  logic               r_in_service;
  logic [VEC_W-1:0]   r_vec_id;

  logic [NUM_SRC-1:0] w_edge;
  logic [NUM_SRC-1:0] w_eligible;
  logic [VEC_W-1:0]   w_win_idx;
  logic               w_win_valid;
  logic               w_req_valid;
  logic               w_enter;

  assign w_edge      = irq & ~r_irq_prev;
  assign w_eligible  = r_pending & irq_en;
  assign w_req_valid = r_gie && (r_state == ST_IDLE) && w_win_valid;
  assign w_enter     = (r_state == ST_IDLE) && (w_next_state == ST_DRAIN);

  irq_prio_enc u_prio_enc (
    .i_req   (w_eligible),
    .o_idx   (w_win_idx),
    .o_valid (w_win_valid)
  );

  assign vec_id        = r_vec_id;
  assign in_service    = r_in_service;
  assign o_dbg_state   = r_state;
  assign o_dbg_pending = r_pending;

  // Next-state and Moore output decode.
  always_comb begin
    w_next_state = r_state;
    stall        = 1'b0;
    flush        = 1'b0;
    push_pc      = 1'b0;
    push_flags   = 1'b0;
    pop_pc       = 1'b0;
    pop_flags    = 1'b0;
    load_vec     = 1'b0;
    ack          = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_req_valid)                w_next_state = ST_DRAIN;
        else if (rti && r_in_service)   w_next_state = ST_POP_FLAGS;
      end
      ST_DRAIN: begin
        stall = 1'b1;
        flush = (r_cnt == LP_CNT_LOAD);
        if (r_cnt == '0) w_next_state = ST_PUSH_PC;
      end
      ST_PUSH_PC: begin
        stall   = 1'b1;
        push_pc = 1'b1;
        if (!mem_busy) w_next_state = ST_PUSH_FLAGS;
      end
      ST_PUSH_FLAGS: begin
        stall      = 1'b1;
        push_flags = 1'b1;
        if (!mem_busy) w_next_state = ST_VECTOR;
      end
      ST_VECTOR: begin
        stall        = 1'b1;
        load_vec     = 1'b1;
        ack          = NUM_SRC'(1) << r_vec_id;
        w_next_state = ST_IDLE;
      end
      ST_POP_FLAGS: begin
        stall     = 1'b1;
        pop_flags = 1'b1;
        if (!mem_busy) w_next_state = ST_POP_PC;
      end
      ST_POP_PC: begin
        stall  = 1'b1;
        pop_pc = 1'b1;
        if (!mem_busy) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next_state;
  end

  // Drain down-counter: loaded on entry, counts to zero while draining.
  always_ff @(posedge clk) begin
    if (!rst)                                r_cnt <= '0;
    else if (w_enter)                        r_cnt <= LP_CNT_LOAD;
    else if (r_state == ST_DRAIN && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
  end

  // Winner is captured at entry and held through the handler.
  always_ff @(posedge clk) begin
    if (!rst)         r_vec_id <= '0;
    else if (w_enter) r_vec_id <= w_win_idx;
  end

  // Edge capture into pending; a fresh edge wins over the ack clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_irq_prev <= '0;
      r_pending  <= '0;
    end else begin
      r_irq_prev <= irq;
      r_pending  <= (r_pending & ~ack) | w_edge;
    end
  end

  // Global enable and handler-active flags toggle at vector and final pop.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_gie        <= 1'b1;
      r_in_service <= 1'b0;
    end else if (r_state == ST_VECTOR) begin
      r_gie        <= 1'b0;
      r_in_service <= 1'b1;
    end else if (r_state == ST_POP_PC && !mem_busy) begin
      r_gie        <= 1'b1;
      r_in_service <= 1'b0;
    end
  end

endmodule

// File: tb/tb_interrupt_scheduler.sv
// Self-checking bench for interrupt_scheduler.
module tb_interrupt_scheduler;
  import int_sched_pkg::*;

  localparam int D  = 2;
  localparam int EW = 19;  // {cycle_checked, vec_id[1:0], load_cycle[15:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- DUT ----------------
  logic [3:0] irq = '0, irq_en = 4'b1111;
  logic       rti = 1'b0, mem_busy = 1'b0;
  logic       stall, flush, push_pc, push_flags, pop_pc, pop_flags, load_vec, in_service;
  logic [1:0] vec_id;
  logic [3:0] ack, dbg_pending;
  state_t     dbg_state;

  interrupt_scheduler #(.DRAIN_CYCLES(D)) dut (
    .clk(clk), .rst(rst), .irq(irq), .irq_en(irq_en), .rti(rti),
    .mem_busy(mem_busy), .stall(stall), .flush(flush), .push_pc(push_pc),
    .push_flags(push_flags), .pop_pc(pop_pc), .pop_flags(pop_flags),
    .load_vec(load_vec), .vec_id(vec_id), .ack(ack), .in_service(in_service),
    .o_dbg_state(dbg_state), .o_dbg_pending(dbg_pending)
  );

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int n_total = 0, n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Per-output activity counters, sampled mid-cycle.
  int n_stall = 0, n_flush = 0, n_ppc = 0, n_pfl = 0, n_opc = 0, n_ofl = 0, n_load = 0, n_ack = 0;
  int b_stall, b_flush, b_ppc, b_pfl, b_opc, b_ofl, b_load, b_ack;

  initial forever begin
    logic [EW-1:0] e;
    logic [3:0]    vid;
    logic [3:0]    exp_ack;
    @(negedge clk);
    if (stall)      n_stall++;
    if (flush)      n_flush++;
    if (push_pc)    n_ppc++;
    if (push_flags) n_pfl++;
    if (pop_pc)     n_opc++;
    if (pop_flags)  n_ofl++;
    if (ack != '0)  n_ack++;
    if (load_vec) begin
      n_load++;
      if (exp_q.size() == 0) begin
        check("unexpected_load", 32'(load_vec), 32'(0));
      end else begin
        e       = exp_q.pop_front();
        vid     = {2'b00, e[17:16]};
        exp_ack = 4'b0001 << vid;
        check("vec_id", 32'(vec_id), 32'(vid));
        check("ack", 32'(ack), 32'(exp_ack));
        if (e[18]) check("load_cycle", 32'(cyc), 32'(e[15:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic snap();
    b_stall = n_stall; b_flush = n_flush; b_ppc = n_ppc; b_pfl = n_pfl;
    b_opc = n_opc; b_ofl = n_ofl; b_load = n_load; b_ack = n_ack;
  endtask

  task automatic expect_entry(input logic timed, input logic [1:0] vid, input int load_cyc);
    exp_q.push_back({timed, vid, 16'(load_cyc)});
  endtask

  task automatic wait_loads(input int target, input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (n_load - b_load >= target) break;
    end
    check(tag, 32'(n_load - b_load), 32'(target));
    tick(1);
  endtask

  task automatic pulse_rti();
    rti = 1'b1;
    tick(1);
    rti = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int k;

  initial begin
    tick(3);
    // Reset state.
    check("rst_stall", 32'(stall), 0);
    check("rst_flush", 32'(flush), 0);
    check("rst_inserv", 32'(in_service), 0);
    check("rst_vec", 32'(vec_id), 0);
    check("rst_ack", 32'(ack), 0);
    check("rst_pending", 32'(dbg_pending), 0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b1;
    tick(2);

    // Single edge on source 2.
    snap();
    irq = 4'b0100;
    k = cyc + 1;
    expect_entry(1'b1, 2'd2, k + D + 3);
    wait_loads(1, 40, "t1_load");
    check("t1_stall", 32'(n_stall - b_stall), 32'(D + 3));
    check("t1_flush", 32'(n_flush - b_flush), 1);
    check("t1_push_pc", 32'(n_ppc - b_ppc), 1);
    check("t1_push_fl", 32'(n_pfl - b_pfl), 1);
    check("t1_ack_cnt", 32'(n_ack - b_ack), 1);
    check("t1_inserv", 32'(in_service), 1);
    check("t1_pending", 32'(dbg_pending), 0);
    irq = 4'b0000;
    tick(2);
    snap();
    pulse_rti();
    tick(6);
    check("t1_pop_fl", 32'(n_ofl - b_ofl), 1);
    check("t1_pop_pc", 32'(n_opc - b_opc), 1);
    check("t1_inserv_end", 32'(in_service), 0);

    // RTI while not in service is ignored.
    snap();
    pulse_rti();
    tick(5);
    check("t2_pop_fl", 32'(n_ofl - b_ofl), 0);
    check("t2_pop_pc", 32'(n_opc - b_opc), 0);
    check("t2_stall", 32'(n_stall - b_stall), 0);

    // Simultaneous edges on sources 1 and 3: 1 first, 3 after RTI.
    snap();
    irq = 4'b1010;
    k = cyc + 1;
    expect_entry(1'b1, 2'd1, k + D + 3);
    expect_entry(1'b0, 2'd3, 0);
    wait_loads(1, 40, "t3_first");
    irq = 4'b0000;
    tick(8);
    check("t3_no_nest", 32'(n_load - b_load), 1);
    check("t3_pending", 32'(dbg_pending), 32'(4'b1000));
    pulse_rti();
    wait_loads(2, 40, "t3_second");
    check("t3_inserv", 32'(in_service), 1);
    pulse_rti();
    tick(6);
    check("t3_inserv_end", 32'(in_service), 0);

    // mem_busy for 3 cycles while PUSH_PC is requested.
    snap();
    irq = 4'b0001;
    k = cyc + 1;
    expect_entry(1'b1, 2'd0, k + D + 6);
    tick(4);
    check("t4_in_push", 32'(push_pc), 1);
    mem_busy = 1'b1;
    tick(3);
    mem_busy = 1'b0;
    wait_loads(1, 40, "t4_load");
    check("t4_push_pc", 32'(n_ppc - b_ppc), 4);
    check("t4_push_fl", 32'(n_pfl - b_pfl), 1);
    check("t4_stall", 32'(n_stall - b_stall), 32'(D + 6));
    irq = 4'b0000;
    pulse_rti();
    tick(6);

    // Masked source stays pending; unmasking releases it.
    snap();
    irq_en = 4'b1110;
    irq = 4'b0001;
    tick(10);
    check("t5_masked_stall", 32'(n_stall - b_stall), 0);
    check("t5_kept_pending", 32'(dbg_pending), 32'(4'b0001));
    irq = 4'b0000;
    tick(2);
    irq_en = 4'b1111;
    expect_entry(1'b1, 2'd0, cyc + D + 3);
    wait_loads(1, 40, "t5_load");
    pulse_rti();
    tick(6);

    // Reset during PUSH_FLAGS, irq held high through reset.
    snap();
    irq = 4'b0100;
    k = cyc + 1;
    tick(5);
    check("t6_in_pushfl", 32'(push_flags), 1);
    rst = 1'b0;
    tick(1);
    check("t6_stall", 32'(stall), 0);
    check("t6_push_fl", 32'(push_flags), 0);
    check("t6_load", 32'(load_vec), 0);
    check("t6_ack", 32'(ack), 0);
    check("t6_vec", 32'(vec_id), 0);
    check("t6_pending", 32'(dbg_pending), 0);
    check("t6_state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b1;
    check("t6_no_ack", 32'(n_ack - b_ack), 0);
    snap();
    expect_entry(1'b1, 2'd2, k + 6 + D + 3);
    wait_loads(1, 40, "t6_reentry");
    irq = 4'b0000;
    pulse_rti();
    tick(6);
    check("t6_inserv_end", 32'(in_service), 0);

    check("queue_empty", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/interrupt_scheduler.md
INTERRUPT_SCHEDULER -- requirements
Module: interrupt_scheduler

Interface
REQ-001 Parameter: DRAIN_CYCLES, 2, number of stall cycles (1..15) spent draining the pipeline before the context push.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-low (rst=0 sampled at a clk rising edge resets the block).
REQ-004 Port: irq  input  4  interrupt lines; bit 0 has the highest priority.
REQ-005 Port: irq_en  input  4  per-source enable mask.
REQ-006 Port: rti  input  1  return-from-interrupt decoded in the pipeline; one-cycle pulse.
REQ-007 Port: mem_busy  input  1  data memory busy; stack push/pop cannot complete while high.
REQ-008 Port: stall  output  1  freeze fetch/decode.
REQ-009 Port: flush  output  1  squash the instruction in decode.
REQ-010 Port: push_pc, push_flags, pop_pc, pop_flags  output  1 each  stack operation requests to the memory stage.
REQ-011 Port: load_vec  output  1  PC loads the vector for vec_id.
REQ-012 Port: vec_id  output  2  latched winning source.
REQ-013 Port: ack  output  4  one-hot, one-cycle acknowledge to the source.
REQ-014 Port: in_service  output  1  handler active; no nesting.

Function
REQ-015 pending[i] SHALL set on an irq[i] rising edge (irq[i]=1 with previous sample 0) and clear on ack[i]; a new edge in the ack cycle keeps pending[i]=1.
REQ-016 Eligible = pending & irq_en; the request is valid only when gie=1, the state is IDLE, and eligible is nonzero.
REQ-017 Winner = lowest-index eligible bit; it is latched into vec_id on the IDLE->DRAIN transition and held until the next entry.
REQ-018 States: IDLE, DRAIN, PUSH_PC, PUSH_FLAGS, VECTOR, POP_FLAGS, POP_PC; all outputs are Moore-decoded from the state.
REQ-019 IDLE->DRAIN on a valid request; DRAIN asserts stall, asserts flush only in its first cycle, and lasts exactly DRAIN_CYCLES cycles (down-counter).
REQ-020 PUSH_PC: stall=1, push_pc=1; advance to PUSH_FLAGS only in a cycle with mem_busy=0. PUSH_FLAGS: stall=1, push_flags=1, same rule, then VECTOR.
REQ-021 VECTOR: exactly one cycle; stall=1, load_vec=1, ack[vec_id]=1; on exit clear gie, set in_service, return to IDLE.
REQ-022 IDLE with rti=1 and in_service=1 -> POP_FLAGS then POP_PC (stall=1, pop_* asserted, mem_busy rule as in REQ-020); on POP_PC exit set gie, clear in_service, return to IDLE.
REQ-023 rti with in_service=0 SHALL be ignored; rti outside IDLE SHALL be ignored.
REQ-024 Edges arriving while not in IDLE or while gie=0 SHALL stay pending and be served after RTI completes, highest priority first.
REQ-025 Latency with mem_busy=0: edge sampled at cycle k -> DRAIN at k+1 ... load_vec at k+DRAIN_CYCLES+3 -> IDLE at k+DRAIN_CYCLES+4.
REQ-026 Deasserting irq_en[i] while pending[i]=1 SHALL mask the source without clearing pending[i].

Reset
REQ-027 rst=0 at a clk edge: state=IDLE, pending=0, previous irq sample=0, gie=1, in_service=0, vec_id=0, counter=0, and all outputs 0 in the following cycle.
REQ-028 Reset mid-sequence SHALL abort immediately with no further push/pop/ack; an irq held high through reset SHALL register as an edge in the first cycle after release.

Structure
REQ-029 The state encoding, NUM_SRC=4, and the vec_id width SHALL live in the shared package int_sched_pkg.
REQ-030 The fixed-priority 4:2 encoder with a valid flag SHALL be the sub-module irq_prio_enc; the rest of the block is a single FSM.

Verification
REQ-031 Single edge on irq=0100, irq_en=1111, mem_busy=0 -> stall for 5 cycles, flush in cycle 1, load_vec with vec_id=2 at k+5, ack=0100 at k+5, in_service=1.
REQ-032 Simultaneous edges on irq=1010 -> vec_id=1 first; after the RTI sequence, second entry with vec_id=3; no nesting in between.
REQ-033 mem_busy=1 for 3 cycles during PUSH_PC -> push_pc held 4 cycles; push_flags asserted exactly once afterwards; total entry 3 cycles longer.
REQ-034 irq_en=1110 with an edge on irq[0] -> no stall; setting irq_en=1111 later -> entry with vec_id=0.
REQ-035 rti with in_service=0 -> no pop; rti in service -> pop_flags then pop_pc, gie=1, in_service=0.
REQ-036 rst=0 during PUSH_FLAGS -> all outputs 0 next cycle, pending=0, no ack issued.
